trace_capture: RTL

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture_pkg.sv | 16 +
 rtl/tc_ram.sv | 27 ++
 rtl/trace_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_pkg.sv
// rtl/trace_capture_pkg.sv - FSM state encoding and trigger-mode constants for trace_capture
package trace_capture_pkg;

    typedef logic [2:0] tc_state_t;

    localparam tc_state_t ST_IDLE = 3'd0;
    localparam tc_state_t ST_PRE  = 3'd1;
    localparam tc_state_t ST_WAIT = 3'd2;
    localparam tc_state_t ST_POST = 3'd3;
    localparam tc_state_t ST_DONE = 3'd4;
    localparam tc_state_t ST_READ = 3'd5;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/tc_ram.sv
// rtl/tc_ram.sv - simple dual-port capture RAM, synchronous write, registered read
module tc_ram #(
    parameter int DATA_W = 28,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - triggered logic-analyzer capture with pre-trigger window and stream readout
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DATA_W   = 28,
    parameter int DEPTH    = 256,
    parameter int TRIG_W   = 1,
    parameter int PRE_TRIG = 64
) (
    input  logic              lcd_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TRIG_W-1:0] trig_i,
    input  logic [TRIG_W-1:0] trig_mask_i,
    input  logic [TRIG_W-1:0] trig_val_i,
    input  logic              trig_edge_i,
    input  logic              arm_i,
    input  logic              abort_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              triggered_o,
    output logic              done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PRE_N   = (AW+1)'(PRE_TRIG);
    localparam logic [AW:0]   POST_N  = (AW+1)'(DEPTH - PRE_TRIG);
    localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_N  = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFF = AW'(PRE_TRIG);

    tc_state_t         r_state;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_trig_ptr;
    logic [AW:0]       r_cnt;
    logic [AW:0]       r_issued;
    logic              r_prev_match;
    logic              r_triggered;
    logic              r_done;

    logic              r_inflight;
    logic              r_inflight_last;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_last;
    logic [1:0]        r_buf_cnt;
    logic              r_head;
    logic              r_tail;

    logic              w_match;
    logic              w_hit;
    logic              w_abort;
    logic              w_we;
    logic              w_valid;
    logic              w_pop;
    logic              w_issue;
    logic [DATA_W-1:0] w_ram_q;

    assign w_match = ((trig_i & trig_mask_i) == (trig_val_i & trig_mask_i));
    assign w_hit   = (trig_edge_i == TRIG_EDGE) ? (w_match && !r_prev_match) : w_match;
    assign w_abort = abort_i && (r_state != ST_IDLE);
    assign w_we    = !abort_i && ((r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST));
    assign w_valid = (r_buf_cnt != 2'd0);
    assign w_pop   = w_valid && rd_ready_i;
    // Issue a RAM read only if the skid buffer will have a free slot when the data lands.
    assign w_issue = (r_state == ST_READ) && !abort_i && (r_issued != DEPTH_N) &&
                     (({1'b0, r_buf_cnt} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

    assign rd_valid_o  = w_valid;
    assign rd_data_o   = r_buf_data[r_head];
    assign rd_last_o   = w_valid && r_buf_last[r_head];
    assign busy_o      = (r_state != ST_IDLE);
    assign triggered_o = r_triggered;
    assign done_o      = r_done;

    tc_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .i_clk   (lcd_clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_i),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge lcd_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_trig_ptr   <= '0;
            r_cnt        <= '0;
            r_issued     <= '0;
            r_prev_match <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
        end else if (w_abort) begin
            r_state     <= ST_IDLE;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_prev_match <= w_match;
            end
            case (r_state)
                ST_IDLE: begin
                    if (arm_i) begin
                        r_wr_ptr <= '0;
                        r_cnt    <= '0;
                        r_issued <= '0;
                        // Seeding with the arm-cycle match keeps an already-true level from looking like an edge.
                        r_prev_match <= w_match;
                        r_state  <= (PRE_TRIG == 0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if ((r_cnt + 1'b1) == PRE_N) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_hit) begin
                        r_trig_ptr  <= r_wr_ptr;
                        r_triggered <= 1'b1;
                        r_cnt       <= (AW+1)'(1);
                        if (POST_N == (AW+1)'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    r_cnt <= r_cnt + 1'b1;
                    if ((r_cnt + 1'b1) == POST_N) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rd_ptr <= r_trig_ptr - PRE_OFF;
                    r_issued <= '0;
                    r_state  <= ST_READ;
                end
                ST_READ: begin
                    if (w_issue) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        r_issued <= r_issued + 1'b1;
                    end
                    if (w_pop && rd_last_o) begin
                        r_triggered <= 1'b0;
                        r_done      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge lcd_clk) begin
        if (rst) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf_data[0]   <= '0;
            r_buf_data[1]   <= '0;
            r_buf_last      <= 2'b00;
            r_buf_cnt       <= 2'd0;
            r_head          <= 1'b0;
            r_tail          <= 1'b0;
        end else if (w_abort) begin
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= (r_issued == LAST_N);
            if (r_inflight) begin
                r_buf_data[r_tail] <= w_ram_q;
                r_buf_last[r_tail] <= r_inflight_last;
                r_tail             <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_buf_cnt <= r_buf_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
